// File: rtl/depth_book_updater.sv
// -----------------------------------------------------------------------------
// depth_book_updater
//
// Applies parsed market-depth events to a sorted, fixed-depth price-level book
// (one per side) and publishes a registered top-of-book snapshot after every
// applied event.
//
// Each event takes three cycles: IDLE (accept), EVAL (compare the event price
// against every level of its side), APPLY (write the book). The snapshot is
// registered from the updated book one cycle after APPLY.
//
// Parameters:
//   LEVELS  price levels held per side (2..16)
//   CNT_W   width of the saturating statistics counters
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   s_evt_tdata/tvalid/tready
//                       AXI-Stream event input; record layout:
//                       [224:161] ts_ns, [160:97] update_id, [96] side
//                       (0 bid, 1 ask), [95:64] price, [63:32] qty;
//                       [255:225] and [31:0] are ignored
//   tob_valid           one-cycle pulse when the TOB outputs were refreshed
//   tob_bid_ok/px/qty   best bid level (ok = level occupied)
//   tob_ask_ok/px/qty   best ask level
//   tob_update_id/ts_ns id and timestamp of the event that was applied
//   stale_cnt           events rejected because update_id did not advance
//   drop_cnt            inserts discarded (side full, price worse than all)
//   miss_cnt            deletes with no matching price
//
// Optional build macro DEPTH_BOOK_CROSS_CHECK_EN adds:
//   book_crossed        sticky flag: best bid >= best ask seen after an apply
//   cross_cnt           number of applies that left the book crossed
// -----------------------------------------------------------------------------
module depth_book_updater #(
  parameter int LEVELS = 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [255:0]     s_evt_tdata,
  input  logic             s_evt_tvalid,
  output logic             s_evt_tready,
  output logic             tob_valid,
  output logic             tob_bid_ok,
  output logic [31:0]      tob_bid_px,
  output logic [31:0]      tob_bid_qty,
  output logic             tob_ask_ok,
  output logic [31:0]      tob_ask_px,
  output logic [31:0]      tob_ask_qty,
  output logic [63:0]      tob_update_id,
  output logic [63:0]      tob_ts_ns,
`ifdef DEPTH_BOOK_CROSS_CHECK_EN
  output logic             book_crossed,
  output logic [CNT_W-1:0] cross_cnt,
`endif
  output logic [CNT_W-1:0] stale_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W = $clog2(LEVELS + 1);

  typedef enum logic [1:0] {IDLE, EVAL, APPLY} state_t;

  state_t state_reg, state_next;

  // Latched event
  logic             evt_side_reg;
  logic [31:0]      evt_px_reg;
  logic [31:0]      evt_qty_reg;
  logic [63:0]      evt_id_reg;
  logic [63:0]      evt_ts_reg;

  // EVAL results
  logic             match_hit_reg;
  logic [IDX_W-1:0] match_idx_reg;
  logic [IDX_W-1:0] ins_idx_reg;
  logic             stale_reg;

  // Staleness tracking
  logic [63:0]      last_id_reg;
  logic             first_done_reg;

  // Snapshot / counters
  logic             tob_pend_reg;
  logic             tob_valid_reg;
  logic             tob_bid_ok_reg, tob_ask_ok_reg;
  logic [31:0]      tob_bid_px_reg, tob_bid_qty_reg;
  logic [31:0]      tob_ask_px_reg, tob_ask_qty_reg;
  logic [63:0]      tob_update_id_reg, tob_ts_ns_reg;
  logic [CNT_W-1:0] stale_cnt_reg, drop_cnt_reg, miss_cnt_reg;

  // Selected-side view of the book and level-0 of both sides
  logic [LEVELS-1:0]       sel_vld;
  logic [LEVELS-1:0][31:0] sel_px;
  logic [LEVELS-1:0][31:0] sel_qty;
  logic                    top_bid_vld, top_ask_vld;
  logic [31:0]             top_bid_px, top_bid_qty, top_ask_px, top_ask_qty;

  // Per-level compare results
  logic [LEVELS-1:0] hit_vec;
  logic [LEVELS-1:0] worse_vec;
  logic              match_hit_c;
  logic [IDX_W-1:0]  match_idx_c;
  logic [IDX_W-1:0]  ins_idx_c;
  logic              stale_c;

  // Apply decode
  logic in_apply, qty_nz;
  logic do_update, do_insert, do_drop, do_delete, do_miss;

  logic unused_tdata;
  assign unused_tdata = ^{s_evt_tdata[255:225], s_evt_tdata[31:0]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    s_evt_tready = 1'b0;
    case (state_reg)
      IDLE: begin
        s_evt_tready = 1'b1;
        if (s_evt_tvalid) state_next = EVAL;
      end
      EVAL:    state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // EVAL compare: "worse" means further from the top of book than the event.
  // ins_idx defaults to the valid count; the lowest worse slot overrides it.
  // ---------------------------------------------------------------------------
  always_comb begin
    match_hit_c = |hit_vec;
    match_idx_c = '0;
    ins_idx_c   = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (sel_vld[i]) ins_idx_c = IDX_W'(i + 1);
    end
    for (int i = LEVELS - 1; i >= 0; i--) begin
      if (hit_vec[i])   match_idx_c = IDX_W'(i);
      if (worse_vec[i]) ins_idx_c   = IDX_W'(i);
    end
  end

  assign stale_c = first_done_reg && (evt_id_reg <= last_id_reg);

  assign in_apply  = (state_reg == APPLY) && !stale_reg;
  assign qty_nz    = |evt_qty_reg;
  assign do_update = in_apply &&  qty_nz &&  match_hit_reg;
  assign do_insert = in_apply &&  qty_nz && !match_hit_reg && (ins_idx_reg <  IDX_W'(LEVELS));
  assign do_drop   = in_apply &&  qty_nz && !match_hit_reg && (ins_idx_reg == IDX_W'(LEVELS));
  assign do_delete = in_apply && !qty_nz &&  match_hit_reg;
  assign do_miss   = in_apply && !qty_nz && !match_hit_reg;

  // ---------------------------------------------------------------------------
  // Book levels. Each level owns its bid and ask entry; during APPLY only the
  // event's side is written. Invalid slots are kept all-zero.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < LEVELS; gi++) begin : g_lvl
    logic        vld_reg [2];
    logic [31:0] px_reg  [2];
    logic [31:0] qty_reg [2];
    logic        dn_vld, up_vld;
    logic [31:0] dn_px, dn_qty, up_px, up_qty;
    logic        nxt_vld;
    logic [31:0] nxt_px, nxt_qty;

    assign sel_vld[gi] = vld_reg[evt_side_reg];
    assign sel_px[gi]  = px_reg[evt_side_reg];
    assign sel_qty[gi] = qty_reg[evt_side_reg];

    assign hit_vec[gi]   = sel_vld[gi] && (sel_px[gi] == evt_px_reg);
    assign worse_vec[gi] = sel_vld[gi] && (evt_side_reg ? (sel_px[gi] > evt_px_reg)
                                                        : (sel_px[gi] < evt_px_reg));

    // Neighbour entries used by insert (shift down) and delete (shift up)
    if (gi == 0) begin : g_dn_none
      assign dn_vld = 1'b0;
      assign dn_px  = '0;
      assign dn_qty = '0;
      assign top_bid_vld = vld_reg[0];
      assign top_bid_px  = px_reg[0];
      assign top_bid_qty = qty_reg[0];
      assign top_ask_vld = vld_reg[1];
      assign top_ask_px  = px_reg[1];
      assign top_ask_qty = qty_reg[1];
    end else begin : g_dn
      assign dn_vld = sel_vld[gi-1];
      assign dn_px  = sel_px[gi-1];
      assign dn_qty = sel_qty[gi-1];
    end

    if (gi == LEVELS - 1) begin : g_up_none
      assign up_vld = 1'b0;
      assign up_px  = '0;
      assign up_qty = '0;
    end else begin : g_up
      assign up_vld = sel_vld[gi+1];
      assign up_px  = sel_px[gi+1];
      assign up_qty = sel_qty[gi+1];
    end

    always_comb begin
      nxt_vld = sel_vld[gi];
      nxt_px  = sel_px[gi];
      nxt_qty = sel_qty[gi];
      if (do_update && (match_idx_reg == IDX_W'(gi))) begin
        nxt_qty = evt_qty_reg;
      end else if (do_insert && (ins_idx_reg == IDX_W'(gi))) begin
        nxt_vld = 1'b1;
        nxt_px  = evt_px_reg;
        nxt_qty = evt_qty_reg;
      end else if (do_insert && (ins_idx_reg < IDX_W'(gi))) begin
        nxt_vld = dn_vld;
        nxt_px  = dn_px;
        nxt_qty = dn_qty;
      end else if (do_delete && (match_idx_reg <= IDX_W'(gi))) begin
        nxt_vld = up_vld;
        nxt_px  = up_px;
        nxt_qty = up_qty;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < 2; s++) begin
          vld_reg[s] <= 1'b0;
          px_reg[s]  <= '0;
          qty_reg[s] <= '0;
        end
      end else if (state_reg == APPLY) begin
        vld_reg[evt_side_reg] <= nxt_vld;
        px_reg[evt_side_reg]  <= nxt_px;
        qty_reg[evt_side_reg] <= nxt_qty;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control, counters and TOB snapshot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      evt_side_reg      <= 1'b0;
      evt_px_reg        <= '0;
      evt_qty_reg       <= '0;
      evt_id_reg        <= '0;
      evt_ts_reg        <= '0;
      match_hit_reg     <= 1'b0;
      match_idx_reg     <= '0;
      ins_idx_reg       <= '0;
      stale_reg         <= 1'b0;
      last_id_reg       <= '0;
      first_done_reg    <= 1'b0;
      tob_pend_reg      <= 1'b0;
      tob_valid_reg     <= 1'b0;
      tob_bid_ok_reg    <= 1'b0;
      tob_bid_px_reg    <= '0;
      tob_bid_qty_reg   <= '0;
      tob_ask_ok_reg    <= 1'b0;
      tob_ask_px_reg    <= '0;
      tob_ask_qty_reg   <= '0;
      tob_update_id_reg <= '0;
      tob_ts_ns_reg     <= '0;
      stale_cnt_reg     <= '0;
      drop_cnt_reg      <= '0;
      miss_cnt_reg      <= '0;
    end else begin
      state_reg <= state_next;

      if (s_evt_tready && s_evt_tvalid) begin
        evt_ts_reg   <= s_evt_tdata[224:161];
        evt_id_reg   <= s_evt_tdata[160:97];
        evt_side_reg <= s_evt_tdata[96];
        evt_px_reg   <= s_evt_tdata[95:64];
        evt_qty_reg  <= s_evt_tdata[63:32];
      end

      if (state_reg == EVAL) begin
        match_hit_reg <= match_hit_c;
        match_idx_reg <= match_idx_c;
        ins_idx_reg   <= ins_idx_c;
        stale_reg     <= stale_c;
      end

      if (state_reg == APPLY) begin
        if (stale_reg) begin
          stale_cnt_reg <= sat_inc(stale_cnt_reg);
        end else begin
          last_id_reg    <= evt_id_reg;
          first_done_reg <= 1'b1;
        end
      end
      if (do_drop) drop_cnt_reg <= sat_inc(drop_cnt_reg);
      if (do_miss) miss_cnt_reg <= sat_inc(miss_cnt_reg);

      // Snapshot is taken the cycle after APPLY so it reflects the new book.
      tob_pend_reg  <= in_apply;
      tob_valid_reg <= tob_pend_reg;
      if (tob_pend_reg) begin
        tob_bid_ok_reg    <= top_bid_vld;
        tob_bid_px_reg    <= top_bid_px;
        tob_bid_qty_reg   <= top_bid_qty;
        tob_ask_ok_reg    <= top_ask_vld;
        tob_ask_px_reg    <= top_ask_px;
        tob_ask_qty_reg   <= top_ask_qty;
        tob_update_id_reg <= evt_id_reg;
        tob_ts_ns_reg     <= evt_ts_reg;
      end
    end
  end

  assign tob_valid     = tob_valid_reg;
  assign tob_bid_ok    = tob_bid_ok_reg;
  assign tob_bid_px    = tob_bid_px_reg;
  assign tob_bid_qty   = tob_bid_qty_reg;
  assign tob_ask_ok    = tob_ask_ok_reg;
  assign tob_ask_px    = tob_ask_px_reg;
  assign tob_ask_qty   = tob_ask_qty_reg;
  assign tob_update_id = tob_update_id_reg;
  assign tob_ts_ns     = tob_ts_ns_reg;
  assign stale_cnt     = stale_cnt_reg;
  assign drop_cnt      = drop_cnt_reg;
  assign miss_cnt      = miss_cnt_reg;

`ifdef DEPTH_BOOK_CROSS_CHECK_EN
  // Crossed-book monitor: evaluated on the post-APPLY book, never modifies it.
  logic             apply_done_reg;
  logic             book_crossed_reg;
  logic [CNT_W-1:0] cross_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      apply_done_reg   <= 1'b0;
      book_crossed_reg <= 1'b0;
      cross_cnt_reg    <= '0;
    end else begin
      apply_done_reg <= (state_reg == APPLY);
      if (apply_done_reg && top_bid_vld && top_ask_vld && (top_bid_px >= top_ask_px)) begin
        book_crossed_reg <= 1'b1;
        cross_cnt_reg    <= sat_inc(cross_cnt_reg);
      end
    end
  end

  assign book_crossed = book_crossed_reg;
  assign cross_cnt    = cross_cnt_reg;
`endif

endmodule

// File: tb/tb_depth_book_updater.sv
`timescale 1ns/1ps
module tb_depth_book_updater;

  localparam int L  = 4;
  localparam int CW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [255:0]   s_evt_tdata;
  logic           s_evt_tvalid;
  logic           s_evt_tready;
  logic           tob_valid;
  logic           tob_bid_ok, tob_ask_ok;
  logic [31:0]    tob_bid_px, tob_bid_qty, tob_ask_px, tob_ask_qty;
  logic [63:0]    tob_update_id, tob_ts_ns;
  logic [CW-1:0]  stale_cnt, drop_cnt, miss_cnt;
`ifdef DEPTH_BOOK_CROSS_CHECK_EN
  logic           book_crossed;
  logic [CW-1:0]  cross_cnt;
`endif

  always #5 clk = ~clk;

  depth_book_updater #(.LEVELS(L), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_evt_tdata   (s_evt_tdata),
    .s_evt_tvalid  (s_evt_tvalid),
    .s_evt_tready  (s_evt_tready),
    .tob_valid     (tob_valid),
    .tob_bid_ok    (tob_bid_ok),
    .tob_bid_px    (tob_bid_px),
    .tob_bid_qty   (tob_bid_qty),
    .tob_ask_ok    (tob_ask_ok),
    .tob_ask_px    (tob_ask_px),
    .tob_ask_qty   (tob_ask_qty),
    .tob_update_id (tob_update_id),
    .tob_ts_ns     (tob_ts_ns),
`ifdef DEPTH_BOOK_CROSS_CHECK_EN
    .book_crossed  (book_crossed),
    .cross_cnt     (cross_cnt),
`endif
    .stale_cnt     (stale_cnt),
    .drop_cnt      (drop_cnt),
    .miss_cnt      (miss_cnt)
  );

  // ---------------------------------------------------------------------------
  // Reference model: each side is a queue ordered best-first.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] px;
    logic [31:0] qty;
  } lvl_t;

  lvl_t        bid_q[$];
  lvl_t        ask_q[$];
  int unsigned m_stale, m_drop, m_miss, m_cross_cnt;
  logic        m_seen, m_crossed;
  logic [63:0] m_last, m_tob_id, m_tob_ts;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    bid_q.delete();
    ask_q.delete();
    m_stale = 0; m_drop = 0; m_miss = 0; m_cross_cnt = 0;
    m_seen = 1'b0; m_crossed = 1'b0;
    m_last = '0; m_tob_id = '0; m_tob_ts = '0;
  endtask

  task automatic model_apply(input logic side, input logic [31:0] px, input logic [31:0] qty,
                             input logic [63:0] id, input logic [63:0] ts, output logic pulse);
    lvl_t q[$];
    lvl_t e;
    int   hit, pos;
    pulse = 1'b0;
    if (m_seen && id <= m_last) begin
      m_stale++;
    end else begin
      m_seen = 1'b1; m_last = id; m_tob_id = id; m_tob_ts = ts; pulse = 1'b1;
      if (side) q = ask_q; else q = bid_q;
      hit = -1;
      foreach (q[k]) if (q[k].px == px) hit = k;
      if (qty != 0) begin
        if (hit >= 0) begin
          q[hit].qty = qty;
        end else begin
          pos = q.size();
          for (int k = q.size() - 1; k >= 0; k--)
            if (side ? (q[k].px > px) : (q[k].px < px)) pos = k;
          if (pos >= L) m_drop++;
          else begin
            e.px = px; e.qty = qty;
            q.insert(pos, e);
            if (q.size() > L) void'(q.pop_back());
          end
        end
      end else begin
        if (hit >= 0) q.delete(hit);
        else m_miss++;
      end
      if (side) ask_q = q; else bid_q = q;
    end
    if (bid_q.size() > 0 && ask_q.size() > 0 && bid_q[0].px >= ask_q[0].px) begin
      m_crossed = 1'b1;
      m_cross_cnt++;
    end
  endtask

  function automatic logic [255:0] pack(input logic side, input logic [31:0] px, input logic [31:0] qty,
                                        input logic [63:0] id, input logic [63:0] ts);
    logic [255:0] d;
    d          = '0;
    d[224:161] = ts;
    d[160:97]  = id;
    d[96]      = side;
    d[95:64]   = px;
    d[63:32]   = qty;
    d[31:0]    = $urandom;
    return d;
  endfunction

  task automatic check_state(input string ctx);
    chk({ctx, "/bid_ok"}, tob_bid_ok, bid_q.size() > 0);
    if (bid_q.size() > 0) begin
      chk({ctx, "/bid_px"}, tob_bid_px, bid_q[0].px);
      chk({ctx, "/bid_qty"}, tob_bid_qty, bid_q[0].qty);
    end
    chk({ctx, "/ask_ok"}, tob_ask_ok, ask_q.size() > 0);
    if (ask_q.size() > 0) begin
      chk({ctx, "/ask_px"}, tob_ask_px, ask_q[0].px);
      chk({ctx, "/ask_qty"}, tob_ask_qty, ask_q[0].qty);
    end
    chk({ctx, "/update_id"}, tob_update_id, m_tob_id);
    chk({ctx, "/ts_ns"}, tob_ts_ns, m_tob_ts);
    chk({ctx, "/stale_cnt"}, stale_cnt, m_stale);
    chk({ctx, "/drop_cnt"}, drop_cnt, m_drop);
    chk({ctx, "/miss_cnt"}, miss_cnt, m_miss);
`ifdef DEPTH_BOOK_CROSS_CHECK_EN
    chk({ctx, "/book_crossed"}, book_crossed, m_crossed);
    chk({ctx, "/cross_cnt"}, cross_cnt, m_cross_cnt);
`endif
  endtask

  // Send one event, check pulse timing (only in the third cycle after accept)
  // and the resulting snapshot/counters against the model.
  task automatic do_event(input string ctx, input logic side, input logic [31:0] px,
                          input logic [31:0] qty, input logic [63:0] id);
    logic [63:0] ts;
    logic        pulse;
    int          n;
    ts = {$urandom, $urandom};
    @(negedge clk);
    s_evt_tdata  = pack(side, px, qty, id, ts);
    s_evt_tvalid = 1'b1;
    n = 0;
    while (!s_evt_tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({ctx, "/accept_wait"}, n < 20, 1'b1);
    @(posedge clk);
    #1;
    s_evt_tvalid = 1'b0;
    model_apply(side, px, qty, id, ts, pulse);
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s/tob_valid_T%0d", ctx, j), tob_valid, (j == 3) ? pulse : 1'b0);
      if (j == 3) check_state(ctx);
    end
    $display("event %s side=%0d px=%0d qty=%0d id=%0d pulse=%0d", ctx, side, px, qty, id, pulse);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    s_evt_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("reset/tready", s_evt_tready, 1'b1);
    chk("reset/tob_valid", tob_valid, 1'b0);
    chk("reset/bid_px", tob_bid_px, 0);
    chk("reset/bid_qty", tob_bid_qty, 0);
    chk("reset/ask_px", tob_ask_px, 0);
    chk("reset/ask_qty", tob_ask_qty, 0);
    check_state("reset");
    $display("reset done");
  endtask

  initial begin
    int          k, lows, pulses, side_i;
    logic        rdy, p;
    logic [63:0] ts, id, nid;
    logic [31:0] px, qty;

    rst          = 1'b1;
    s_evt_tvalid = 1'b0;
    s_evt_tdata  = '0;
    model_reset();

    // First event latency and contents
    do_reset();
    do_event("first", 1'b0, 32'd100, 32'd5, 64'd1);
    chk("first/bid_px_const", tob_bid_px, 100);
    chk("first/bid_qty_const", tob_bid_qty, 5);
    chk("first/ask_ok_const", tob_ask_ok, 1'b0);
    chk("first/id_const", tob_update_id, 1);

    // Bid ordering and delete
    do_reset();
    do_event("bids1", 1'b0, 32'd100, 32'd1, 64'd1);
    do_event("bids2", 1'b0, 32'd102, 32'd2, 64'd2);
    do_event("bids3", 1'b0, 32'd101, 32'd3, 64'd3);
    chk("bids3/best_const", tob_bid_px, 102);
    do_event("bids_del", 1'b0, 32'd102, 32'd0, 64'd4);
    chk("bids_del/best_const", tob_bid_px, 101);
    chk("bids_del/miss_const", miss_cnt, 0);
    do_event("bids_del2", 1'b0, 32'd101, 32'd0, 64'd5);
    chk("bids_del2/best_const", tob_bid_px, 100);

    // Full ask side: better price evicts worst, worst price is dropped
    do_reset();
    for (int i = 0; i < 4; i++)
      do_event("asks_fill", 1'b1, 32'(10 + i), 32'(i + 1), 64'(i + 1));
    do_event("asks_ins9", 1'b1, 32'd9, 32'd7, 64'd5);
    chk("asks_ins9/best_const", tob_ask_px, 9);
    chk("asks_ins9/drop_const", drop_cnt, 0);
    do_event("asks_drop14", 1'b1, 32'd14, 32'd7, 64'd6);
    chk("asks_drop14/drop_const", drop_cnt, 1);

    // Staleness and delete miss
    do_event("id7", 1'b0, 32'd30, 32'd3, 64'd7);
    do_event("id7_again", 1'b0, 32'd31, 32'd3, 64'd7);
    do_event("id3", 1'b1, 32'd8, 32'd3, 64'd3);
    chk("stale/stale_const", stale_cnt, 2);
    do_event("miss50", 1'b1, 32'd50, 32'd0, 64'd8);
    chk("miss50/miss_const", miss_cnt, 1);

    // Back-to-back records with tvalid held high
    k = 0; lows = 0; pulses = 0;
    ts = 64'h5000;
    s_evt_tdata = pack(1'b0, 32'd200, 32'd1, 64'd9, ts);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      s_evt_tvalid = (k < 4);
      rdy = s_evt_tready;
      if (c < 10 && !rdy) lows++;
      @(posedge clk);
      #1;
      if (tob_valid) pulses++;
      if (rdy && s_evt_tvalid) begin
        model_apply(1'b0, 32'(200 + k), 32'(k + 1), 64'(9 + k), ts, p);
        k++;
        ts = ts + 64'd7;
        s_evt_tdata = pack(1'b0, 32'(200 + k), 32'(k + 1), 64'(9 + k), ts);
      end
    end
    chk("stream/accepted", k, 4);
    chk("stream/tready_low", lows, 6);
    chk("stream/pulses", pulses, 4);
    check_state("stream");
    $display("stream accepted=%0d tready_low=%0d pulses=%0d", k, lows, pulses);

    // Reset while the fifth record is in EVAL
    @(negedge clk);
    s_evt_tdata  = pack(1'b1, 32'd300, 32'd9, 64'd13, 64'h77);
    s_evt_tvalid = 1'b1;
    chk("midrst/tready", s_evt_tready, 1'b1);
    @(posedge clk);
    #1;
    s_evt_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (tob_valid) pulses++;
    end
    chk("midrst/pulses", pulses, 0);
    chk("midrst/tready", s_evt_tready, 1'b1);
    check_state("midrst");
    $display("mid-EVAL reset done");

    // Randomized events against the model
    do_reset();
    nid = 64'd10;
    for (int i = 0; i < 80; i++) begin
      side_i = $urandom_range(0, 1);
      px  = (($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'd0) + 32'(100 + $urandom_range(0, 5));
      qty = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 50));
      if ($urandom_range(0, 7) == 0) id = nid - 64'($urandom_range(0, 1));
      else begin
        nid = nid + 64'($urandom_range(1, 3));
        id  = nid;
      end
      do_event($sformatf("rnd%0d", i), side_i[0], px, qty, id);
    end

`ifdef DEPTH_BOOK_CROSS_CHECK_EN
    do_reset();
    do_event("cross_ask", 1'b1, 32'd104, 32'd1, 64'd1);
    chk("cross_ask/crossed_const", book_crossed, 1'b0);
    do_event("cross_bid", 1'b0, 32'd105, 32'd1, 64'd2);
    chk("cross_bid/crossed_const", book_crossed, 1'b1);
    chk("cross_bid/cnt_const", cross_cnt, 1);
    do_event("cross_del", 1'b0, 32'd105, 32'd0, 64'd3);
    chk("cross_del/crossed_const", book_crossed, 1'b1);
    chk("cross_del/cnt_const", cross_cnt, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
